// File: rtl/rv_skid_slice.sv
// rtl/rv_skid_slice.sv - two-entry registered valid/ready slice with skid enable and stall counter
module rv_skid_slice #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_fire,
   output logic [1:0]        o_occupancy,
   input  logic              i_stat_clr,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_init;
   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] r_skd;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_load_out_in;
   logic              w_load_out_skd;
   logic              w_load_skd;
   logic              w_stall;

   assign w_in_fire   = i_valid & o_ready;
   assign w_out_fire  = o_valid & i_ready;
   assign w_stall     = o_valid & ~i_ready;
   assign o_fire      = w_out_fire;
   assign o_data      = r_out;
   assign o_stall_cnt = r_stall_cnt;

   // State register; reset drops every held beat immediately
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode from the accept/emit handshakes
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_in_fire) w_state_nxt = ST_BUSY;
         ST_BUSY: begin
            if (w_in_fire && !w_out_fire)      w_state_nxt = ST_FULL;
            else if (!w_in_fire && w_out_fire) w_state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (w_out_fire) w_state_nxt = ST_BUSY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   // Output decode: flags come from registers only, so o_ready never sees i_ready
   always_comb begin
      o_valid        = 1'b0;
      o_ready        = 1'b0;
      o_occupancy    = 2'd0;
      w_load_out_in  = 1'b0;
      w_load_out_skd = 1'b0;
      w_load_skd     = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            o_ready       = r_init;
            w_load_out_in = w_in_fire;
         end
         ST_BUSY: begin
            o_valid       = 1'b1;
            o_ready       = r_init;
            o_occupancy   = 2'd1;
            w_load_out_in = w_in_fire & w_out_fire;
            w_load_skd    = w_in_fire & ~w_out_fire;
         end
         ST_FULL: begin
            o_valid        = 1'b1;
            o_occupancy    = 2'd2;
            w_load_out_skd = w_out_fire;
         end
         default: begin
            o_valid = 1'b0;
         end
      endcase
   end

   // Ready is held off for the first cycle after reset release
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_init <= 1'b0;
      end else begin
         r_init <= 1'b1;
      end
   end

   // Payload registers: r_out is always the oldest beat, r_skd the one behind it
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out <= '0;
         r_skd <= '0;
      end else begin
         if (w_load_out_in) begin
            r_out <= i_data;
         end else if (w_load_out_skd) begin
            r_out <= r_skd;
         end
         if (w_load_skd) begin
            r_skd <= i_data;
         end
      end
   end

   // Saturating stall-cycle counter; clear wins over a same-cycle increment
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_stall_cnt <= '0;
      end else if (i_stat_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rv_skid_slice.sv
// tb/tb_rv_skid_slice.sv - directed table, corner sequences and scoreboard run for rv_skid_slice
module tb_rv_skid_slice;

   logic        clk;
   logic        rst_n;
   logic        v;
   logic        rdy;
   logic        clr;
   logic [31:0] d;

   logic        ordy, ov, fire;
   logic [31:0] od;
   logic [1:0]  occ;
   logic [15:0] cnt;

   logic        s_ordy, s_ov, s_fire;
   logic [31:0] s_od;
   logic [1:0]  s_occ;
   logic [1:0]  s_cnt;

   int checks   = 0;
   int failures = 0;

   rv_skid_slice #(.DATA_W(32), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(v), .o_ready(ordy), .i_data(d),
      .o_valid(ov), .i_ready(rdy), .o_data(od), .o_fire(fire), .o_occupancy(occ),
      .i_stat_clr(clr), .o_stall_cnt(cnt)
   );

   rv_skid_slice #(.DATA_W(32), .CNT_W(2)) dut_small (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(v), .o_ready(s_ordy), .i_data(d),
      .o_valid(s_ov), .i_ready(rdy), .o_data(s_od), .o_fire(s_fire), .o_occupancy(s_occ),
      .i_stat_clr(clr), .o_stall_cnt(s_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        v;
      logic        rdy;
      logic [31:0] d;
      logic        e_ov;
      logic        e_ordy;
      logic [1:0]  e_occ;
      logic        e_fire;
      logic [31:0] e_data;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge, outputs settle before the rising edge
   task automatic step(input logic iv, input logic [31:0] id, input logic ir, input logic ic);
      @(negedge clk);
      v   = iv;
      d   = id;
      rdy = ir;
      clr = ic;
      #1;
   endtask

   logic [31:0] q [$];
   logic [31:0] exp_d;
   logic        pend;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        in_f;
   logic        out_f;
   int          bias;

   initial begin
      //             v  rdy d         ov ordy occ fire data      cnt
      tbl[0]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 2'd1, 1'b1, 32'h11, 16'd0};
      tbl[2]  = '{1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 2'd1, 1'b1, 32'h22, 16'd0};
      tbl[3]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 2'd1, 1'b1, 32'h33, 16'd0};
      tbl[4]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00, 16'd0};
      tbl[5]  = '{1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00, 16'd0};
      tbl[6]  = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b1, 2'd1, 1'b0, 32'hA0, 16'd0};
      tbl[7]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 16'd1};
      tbl[8]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 2'd2, 1'b0, 32'hA0, 16'd2};
      tbl[9]  = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 2'd2, 1'b1, 32'hA0, 16'd3};
      tbl[10] = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA1, 16'd3};
      tbl[11] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA2, 16'd3};
      tbl[12] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00, 16'd3};

      rst_n = 1'b0;
      v     = 1'b0;
      rdy   = 1'b1;
      clr   = 1'b0;
      d     = '0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_ready", 32'(ordy), 32'd0);
      chk("rst_data", od, 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_fire", 32'(fire), 32'd0);

      // Release: ready stays low for the first cycle only
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_first", 32'(ordy), 32'd0);

      // Directed table: streaming then backpressure
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
         chk($sformatf("t%0d_valid", i), 32'(ov), 32'(tbl[i].e_ov));
         chk($sformatf("t%0d_ready", i), 32'(ordy), 32'(tbl[i].e_ordy));
         chk($sformatf("t%0d_occ", i), 32'(occ), 32'(tbl[i].e_occ));
         chk($sformatf("t%0d_fire", i), 32'(fire), 32'(tbl[i].e_fire));
         chk($sformatf("t%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
         chk($sformatf("t%0d_s_valid", i), 32'(s_ov), 32'(tbl[i].e_ov));
         chk($sformatf("t%0d_s_ready", i), 32'(s_ordy), 32'(tbl[i].e_ordy));
         chk($sformatf("t%0d_s_occ", i), 32'(s_occ), 32'(tbl[i].e_occ));
         chk($sformatf("t%0d_s_fire", i), 32'(s_fire), 32'(tbl[i].e_fire));
         chk($sformatf("t%0d_s_cnt", i), 32'(s_cnt), 32'(tbl[i].e_cnt[1:0]));
         if (tbl[i].e_ov) begin
            chk($sformatf("t%0d_data", i), od, tbl[i].e_data);
            chk($sformatf("t%0d_s_data", i), s_od, tbl[i].e_data);
         end
      end

      // Stall counter: clear while loading, then count, saturate the 2-bit copy
      step(1'b1, 32'h55, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         chk("stall_hold_data", od, 32'h55);
         if (k == 6) chk("stall_cnt_5", 32'(cnt), 32'd5);
      end
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("stall_cnt_10", 32'(cnt), 32'd10);
      chk("stall_sat_3", 32'(s_cnt), 32'd3);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("stall_clr_prio", 32'(cnt), 32'd0);
      chk("stall_s_clr", 32'(s_cnt), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("stall_after_clr", 32'(cnt), 32'd1);

      // Async reset while FULL
      step(1'b1, 32'hA0, 1'b0, 1'b0);
      @(negedge clk);
      v   = 1'b0;
      rdy = 1'b1;
      #2;
      chk("full_occ", 32'(occ), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ov), 32'd0);
      chk("arst_ready", 32'(ordy), 32'd0);
      chk("arst_occ", 32'(occ), 32'd0);
      chk("arst_fire", 32'(fire), 32'd0);
      chk("arst_cnt", 32'(cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         chk("arst_no_stale", 32'(ov), 32'd0);
      end

      // Random valid/ready against a FIFO scoreboard
      pend       = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int i = 0; i < 10000; i++) begin
         bias = (i / 2500) % 4;
         @(negedge clk);
         if (!pend) begin
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
         end
         rdy = ($urandom_range(0, 3) < bias + 1) ? 1'b1 : 1'b0;
         clr = 1'b0;
         #1;
         in_f  = v & ordy;
         out_f = ov & rdy;
         if (occ !== 2'(q.size())) chk("rnd_occ", 32'(occ), 32'(q.size()));
         if (prev_stall) begin
            chk("rnd_stable_valid", 32'(ov), 32'd1);
            chk("rnd_stable_data", od, prev_data);
         end
         if (out_f) begin
            if (q.size() == 0) begin
               chk("rnd_dup", 32'd1, 32'd0);
            end else begin
               exp_d = q.pop_front();
               chk("rnd_order", od, exp_d);
            end
         end
         if (in_f) q.push_back(d);
         pend       = v & ~in_f;
         prev_stall = ov & ~rdy;
         prev_data  = od;
      end

      // Drain remaining beats
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         v   = 1'b0;
         rdy = 1'b1;
         #1;
         if (ov) begin
            if (q.size() == 0) begin
               chk("drain_dup", 32'd1, 32'd0);
            end else begin
               exp_d = q.pop_front();
               chk("drain_order", od, exp_d);
            end
         end
      end
      chk("drain_lost", 32'(q.size()), 32'd0);
      chk("drain_occ", 32'(occ), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
